// File: rtl/net_data_sender_pkg.sv
// Shared link types and default parameters for the TSPIN game-state transmitter.
package net_data_sender_pkg;

  localparam int unsigned ENC_DATA_BITS  = 218;
  localparam int unsigned LANE_BITS      = ENC_DATA_BITS;
  localparam int unsigned SYNC_BITS      = 8;
  localparam logic [SYNC_BITS-1:0] SYNCWORD = 8'hFF;
  localparam int unsigned TIMEOUT_CYCLES = 100;
  localparam int unsigned MAX_RETRIES    = 7;

  typedef enum logic {
    PID_GE  = 1'b0,
    PID_ACK = 1'b1
  } pid_t;

  typedef enum logic [1:0] {
    IDLE,
    SYNC,
    DATA,
    WAIT_ACK
  } tx_state_t;

  function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/net_data_sender_shifter.sv
// One lane: loadable syncword+payload shift register, MSB first, zero-filled.
module tx_lane_shifter #(
  parameter int unsigned FRAME_BITS = 226
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  load,
  input  logic                  shift,
  input  logic [FRAME_BITS-1:0] load_value,
  output logic                  serial_out
);

  logic [FRAME_BITS-1:0] sr;

  // Load a whole frame, or shift left so the line returns to 0 after the last bit.
  always_ff @(posedge clock) begin
    if (reset)      sr <= '0;
    else if (load)  sr <= load_value;
    else if (shift) sr <= {sr[FRAME_BITS-2:0], 1'b0};
  end

  assign serial_out = sr[FRAME_BITS-1];

endmodule

// File: rtl/net_data_sender.sv
// Multi-lane framed transmitter with handshake wait, GE/timeout resend and retry limit.
module net_data_sender
  import net_data_sender_pkg::*;
#(
  parameter int unsigned NUM_LANES      = 4,
  parameter int unsigned LANE_BITS      = net_data_sender_pkg::LANE_BITS,
  parameter int unsigned SYNC_BITS      = net_data_sender_pkg::SYNC_BITS,
  parameter logic [SYNC_BITS-1:0] SYNCWORD = net_data_sender_pkg::SYNCWORD,
  parameter int unsigned TIMEOUT_CYCLES = net_data_sender_pkg::TIMEOUT_CYCLES,
  parameter int unsigned MAX_RETRIES    = net_data_sender_pkg::MAX_RETRIES
) (
  input  logic                              clock,
  input  logic                              reset,
  input  logic                              send_valid,
  output logic                              send_ready,
  input  logic [NUM_LANES*LANE_BITS-1:0]    send_data,
  input  logic                              send_seq,
  input  logic                              ack_valid,
  input  pid_t                              ack_pid,
  input  logic                              ack_seq,
  output logic [NUM_LANES-1:0]              serial_out,
  output logic                              busy,
  output logic                              done,
  output logic                              fail,
  output logic [$clog2(MAX_RETRIES+1)-1:0]  retry_count
);

  localparam int unsigned CNT_W   = $clog2(max_u(max_u(SYNC_BITS, LANE_BITS), 2));
  localparam int unsigned TIMER_W = $clog2(max_u(TIMEOUT_CYCLES, 2));
  localparam int unsigned RETRY_W = $clog2(MAX_RETRIES + 1);

  localparam logic [CNT_W-1:0]   SYNC_LAST  = CNT_W'(SYNC_BITS - 1);
  localparam logic [CNT_W-1:0]   DATA_LAST  = CNT_W'(LANE_BITS - 1);
  localparam logic [TIMER_W-1:0] TIMER_LAST = TIMER_W'(TIMEOUT_CYCLES - 1);
  localparam logic [RETRY_W-1:0] RETRY_MAX  = RETRY_W'(MAX_RETRIES);

  tx_state_t                     state_q, state_d;
  logic [CNT_W-1:0]              cnt_q, cnt_d;
  logic [TIMER_W-1:0]            timer_q, timer_d;
  logic [RETRY_W-1:0]            retry_q, retry_d;
  logic                          done_q, done_d;
  logic                          fail_q, fail_d;
  logic [NUM_LANES*LANE_BITS-1:0] data_q;
  logic [NUM_LANES*LANE_BITS-1:0] load_src;
  logic                          seq_q;
  logic                          accept, load, shift, ack_match;

  assign send_ready  = (state_q == IDLE);
  assign busy        = (state_q != IDLE);
  assign done        = done_q;
  assign fail        = fail_q;
  assign retry_count = retry_q;
  assign ack_match   = ack_valid && (ack_seq == seq_q);
  // On accept the shifters load straight from the input, since data_q is only written at that same edge.
  assign load_src    = accept ? send_data : data_q;

  // State, counters and outcome pulses.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      timer_q <= '0;
      retry_q <= '0;
      done_q  <= 1'b0;
      fail_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      timer_q <= timer_d;
      retry_q <= retry_d;
      done_q  <= done_d;
      fail_q  <= fail_d;
    end
  end

  // Packet latch, written only on accept so every resend is bit-identical.
  always_ff @(posedge clock) begin
    if (reset) begin
      data_q <= '0;
      seq_q  <= 1'b0;
    end else if (accept) begin
      data_q <= send_data;
      seq_q  <= send_seq;
    end
  end

  // Next-state, counter updates and shifter controls.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    timer_d = timer_q;
    retry_d = retry_q;
    done_d  = 1'b0;
    fail_d  = 1'b0;
    accept  = 1'b0;
    load    = 1'b0;
    shift   = 1'b0;
    case (state_q)
      IDLE: begin
        if (send_valid) begin
          accept  = 1'b1;
          load    = 1'b1;
          retry_d = '0;
          cnt_d   = '0;
          state_d = SYNC;
        end
      end
      SYNC: begin
        shift = 1'b1;
        if (cnt_q == SYNC_LAST) begin
          cnt_d   = '0;
          state_d = DATA;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      DATA: begin
        shift = 1'b1;
        if (cnt_q == DATA_LAST) begin
          cnt_d   = '0;
          timer_d = '0;
          state_d = WAIT_ACK;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      WAIT_ACK: begin
        timer_d = timer_q + TIMER_W'(1);
        // ACK is tested first so an ACK landing on the timeout cycle still completes.
        if (ack_match && (ack_pid == PID_ACK)) begin
          done_d  = 1'b1;
          state_d = IDLE;
        end else if ((ack_match && (ack_pid == PID_GE)) || (timer_q == TIMER_LAST)) begin
          if (retry_q == RETRY_MAX) begin
            fail_d  = 1'b1;
            state_d = IDLE;
          end else begin
            retry_d = retry_q + RETRY_W'(1);
            load    = 1'b1;
            cnt_d   = '0;
            state_d = SYNC;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
    tx_lane_shifter #(
      .FRAME_BITS(SYNC_BITS + LANE_BITS)
    ) u_shifter (
      .clock      (clock),
      .reset      (reset),
      .load       (load),
      .shift      (shift),
      .load_value ({SYNCWORD, load_src[i*LANE_BITS +: LANE_BITS]}),
      .serial_out (serial_out[i])
    );
  end

endmodule

// File: tb/tb_net_data_sender.sv
// Scoreboard bench for net_data_sender: expected lane words queued at stimulus time, popped each cycle.
module tb_net_data_sender;
  import net_data_sender_pkg::*;

  localparam int NL = 4;
  localparam int LB = 8;
  localparam int SB = 8;
  localparam int TO = 10;
  localparam int MR = 2;
  localparam int FR = SB + LB;

  logic          clock = 1'b0;
  logic          reset = 1'b1;
  logic          send_valid = 1'b0;
  logic          send_ready;
  logic [31:0]   send_data = '0;
  logic          send_seq = 1'b0;
  logic          ack_valid = 1'b0;
  pid_t          ack_pid = PID_GE;
  logic          ack_seq = 1'b0;
  logic [3:0]    serial_out;
  logic          busy, done, fail;
  logic [1:0]    retry_count;

  int checks = 0;
  int errors = 0;
  logic [3:0] exp_q[$];
  logic [3:0] exp_w;

  net_data_sender #(
    .NUM_LANES(NL), .LANE_BITS(LB), .SYNC_BITS(SB), .SYNCWORD(8'hFF),
    .TIMEOUT_CYCLES(TO), .MAX_RETRIES(MR)
  ) dut (
    .clock(clock), .reset(reset), .send_valid(send_valid), .send_ready(send_ready),
    .send_data(send_data), .send_seq(send_seq), .ack_valid(ack_valid), .ack_pid(ack_pid),
    .ack_seq(ack_seq), .serial_out(serial_out), .busy(busy), .done(done), .fail(fail),
    .retry_count(retry_count)
  );

  always #5 clock = ~clock;

  // Lane word at frame cycle c: syncword bits first, then lane payload MSB first.
  function automatic logic [3:0] frame_word(input logic [31:0] d, input int c);
    logic [7:0] sw;
    logic [3:0] w;
    sw = 8'hFF;
    for (int i = 0; i < NL; i++)
      w[i] = (c < SB) ? sw[SB-1-c] : d[i*LB + (FR-1-c)];
    return w;
  endfunction

  task automatic push_frame(input logic [31:0] d);
    for (int c = 0; c < FR; c++) exp_q.push_back(frame_word(d, c));
  endtask

  task automatic push_idle(input int n);
    for (int c = 0; c < n; c++) exp_q.push_back(4'h0);
  endtask

  task automatic start_packet(input logic [31:0] d, input logic s);
    send_valid = 1'b1;
    send_data  = d;
    send_seq   = s;
  endtask

  task automatic do_reset();
    @(negedge clock);
    reset = 1'b1; send_valid = 1'b0; ack_valid = 1'b0;
    @(negedge clock);
    @(negedge clock);
    reset = 1'b0;
    exp_q.delete();
  endtask

  task automatic test_reset();
    @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    @(negedge clock);
    checks++; if (serial_out !== 4'h0) begin errors++; $display("FAIL reset_serial got %h exp 0", serial_out); end
    checks++; if (busy !== 1'b0 || done !== 1'b0 || fail !== 1'b0) begin errors++; $display("FAIL reset_flags got busy=%b done=%b fail=%b exp 000", busy, done, fail); end
    checks++; if (retry_count !== 2'd0) begin errors++; $display("FAIL reset_retry got %0d exp 0", retry_count); end
    checks++; if (send_ready !== 1'b1) begin errors++; $display("FAIL reset_ready got %b exp 1", send_ready); end
    reset = 1'b0;
  endtask

  task automatic test_ack();
    do_reset();
    start_packet(32'hA5C3_0F81, 1'b1);
    push_frame(32'hA5C3_0F81); push_idle(3);
    for (int c = 0; c < FR + 3; c++) begin
      @(negedge clock);
      exp_w = exp_q.pop_front();
      checks++; if (serial_out !== exp_w) begin errors++; $display("FAIL ack_frame c=%0d got %h exp %h", c, serial_out, exp_w); end
      if (c == 0) begin
        send_valid = 1'b0;
        checks++; if (send_ready !== 1'b0 || busy !== 1'b1) begin errors++; $display("FAIL ack_busy got ready=%b busy=%b exp 0 1", send_ready, busy); end
      end
      if (c == FR + 2) begin ack_valid = 1'b1; ack_pid = PID_ACK; ack_seq = 1'b1; end
    end
    @(negedge clock);
    ack_valid = 1'b0;
    checks++; if (done !== 1'b1 || fail !== 1'b0) begin errors++; $display("FAIL ack_done got done=%b fail=%b exp 1 0", done, fail); end
    checks++; if (retry_count !== 2'd0 || send_ready !== 1'b1) begin errors++; $display("FAIL ack_state got retry=%0d ready=%b exp 0 1", retry_count, send_ready); end
    @(negedge clock);
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL ack_pulse got %b exp 0", done); end
  endtask

  task automatic test_ge();
    do_reset();
    start_packet(32'hA5C3_0F81, 1'b1);
    push_frame(32'hA5C3_0F81); push_idle(5); push_frame(32'hA5C3_0F81);
    for (int c = 0; c < 2*FR + 5; c++) begin
      @(negedge clock);
      exp_w = exp_q.pop_front();
      checks++; if (serial_out !== exp_w) begin errors++; $display("FAIL ge_frame c=%0d got %h exp %h", c, serial_out, exp_w); end
      if (c == 0) send_valid = 1'b0;
      if (c == FR + 4) begin ack_valid = 1'b1; ack_pid = PID_GE; ack_seq = 1'b1; end
      if (c == FR + 5) begin
        ack_valid = 1'b0;
        checks++; if (retry_count !== 2'd1) begin errors++; $display("FAIL ge_retry got %0d exp 1", retry_count); end
      end
    end
  endtask

  task automatic test_timeout();
    do_reset();
    start_packet(32'h1357_9BDF, 1'b0);
    for (int f = 0; f < 3; f++) begin push_frame(32'h1357_9BDF); push_idle(TO); end
    for (int c = 0; c < 3*(FR + TO); c++) begin
      @(negedge clock);
      exp_w = exp_q.pop_front();
      checks++; if (serial_out !== exp_w) begin errors++; $display("FAIL to_frame c=%0d got %h exp %h", c, serial_out, exp_w); end
      if (c == 0) send_valid = 1'b0;
      if (c % (FR + TO) == 0) begin
        checks++; if (retry_count !== 2'(c / (FR + TO))) begin errors++; $display("FAIL to_retry c=%0d got %0d exp %0d", c, retry_count, c / (FR + TO)); end
      end
    end
    @(negedge clock);
    checks++; if (fail !== 1'b1 || done !== 1'b0) begin errors++; $display("FAIL to_fail got fail=%b done=%b exp 1 0", fail, done); end
    checks++; if (retry_count !== 2'd2 || send_ready !== 1'b1) begin errors++; $display("FAIL to_state got retry=%0d ready=%b exp 2 1", retry_count, send_ready); end
    @(negedge clock);
    checks++; if (fail !== 1'b0 || serial_out !== 4'h0) begin errors++; $display("FAIL to_after got fail=%b serial=%h exp 0 0", fail, serial_out); end
  endtask

  task automatic test_bad_seq();
    do_reset();
    start_packet(32'hA5C3_0F81, 1'b1);
    push_frame(32'hA5C3_0F81); push_idle(TO); push_frame(32'hA5C3_0F81);
    for (int c = 0; c < 2*FR + TO; c++) begin
      @(negedge clock);
      exp_w = exp_q.pop_front();
      checks++; if (serial_out !== exp_w) begin errors++; $display("FAIL seq_frame c=%0d got %h exp %h", c, serial_out, exp_w); end
      if (c == 0) send_valid = 1'b0;
      if (c == FR + 3) begin ack_valid = 1'b1; ack_pid = PID_ACK; ack_seq = 1'b0; end
      if (c == FR + 4) begin
        ack_valid = 1'b0;
        checks++; if (done !== 1'b0 || busy !== 1'b1) begin errors++; $display("FAIL seq_ignored got done=%b busy=%b exp 0 1", done, busy); end
      end
      if (c == FR + TO) begin
        checks++; if (retry_count !== 2'd1) begin errors++; $display("FAIL seq_retry got %0d exp 1", retry_count); end
      end
    end
  endtask

  task automatic test_ack_timeout();
    do_reset();
    start_packet(32'h0F0F_F0F0, 1'b1);
    push_frame(32'h0F0F_F0F0); push_idle(TO + 2);
    for (int c = 0; c < FR + TO; c++) begin
      @(negedge clock);
      exp_w = exp_q.pop_front();
      checks++; if (serial_out !== exp_w) begin errors++; $display("FAIL at_frame c=%0d got %h exp %h", c, serial_out, exp_w); end
      if (c == 0) send_valid = 1'b0;
      if (c == FR + TO - 1) begin ack_valid = 1'b1; ack_pid = PID_ACK; ack_seq = 1'b1; end
    end
    @(negedge clock);
    ack_valid = 1'b0;
    exp_w = exp_q.pop_front();
    checks++; if (done !== 1'b1 || busy !== 1'b0 || serial_out !== exp_w) begin errors++; $display("FAIL at_done got done=%b busy=%b serial=%h exp 1 0 %h", done, busy, serial_out, exp_w); end
    @(negedge clock);
    exp_w = exp_q.pop_front();
    checks++; if (serial_out !== exp_w || retry_count !== 2'd0) begin errors++; $display("FAIL at_noresend got serial=%h retry=%0d exp %h 0", serial_out, retry_count, exp_w); end
  endtask

  task automatic test_mid_reset();
    do_reset();
    start_packet(32'hDEAD_BEEF, 1'b0);
    push_frame(32'hDEAD_BEEF);
    for (int c = 0; c < SB + 4; c++) begin
      @(negedge clock);
      exp_w = exp_q.pop_front();
      checks++; if (serial_out !== exp_w) begin errors++; $display("FAIL mr_frame c=%0d got %h exp %h", c, serial_out, exp_w); end
      if (c == 0) send_valid = 1'b0;
      if (c == SB + 3) reset = 1'b1;
    end
    exp_q.delete();
    @(negedge clock);
    reset = 1'b0;
    checks++; if (serial_out !== 4'h0 || busy !== 1'b0 || send_ready !== 1'b1) begin errors++; $display("FAIL mr_idle got serial=%h busy=%b ready=%b exp 0 0 1", serial_out, busy, send_ready); end
    checks++; if (done !== 1'b0 || fail !== 1'b0) begin errors++; $display("FAIL mr_flags got done=%b fail=%b exp 0 0", done, fail); end
    for (int c = 0; c < 4; c++) begin
      @(negedge clock);
      checks++; if (done !== 1'b0 || fail !== 1'b0 || serial_out !== 4'h0) begin errors++; $display("FAIL mr_quiet got done=%b fail=%b serial=%h exp 0 0 0", done, fail, serial_out); end
    end
    start_packet(32'h1234_5678, 1'b0);
    push_frame(32'h1234_5678); push_idle(1);
    for (int c = 0; c < FR + 1; c++) begin
      @(negedge clock);
      exp_w = exp_q.pop_front();
      checks++; if (serial_out !== exp_w) begin errors++; $display("FAIL mr_new c=%0d got %h exp %h", c, serial_out, exp_w); end
      if (c == 0) send_valid = 1'b0;
      if (c == FR) begin ack_valid = 1'b1; ack_pid = PID_ACK; ack_seq = 1'b0; end
    end
    @(negedge clock);
    ack_valid = 1'b0;
    checks++; if (done !== 1'b1) begin errors++; $display("FAIL mr_done got %b exp 1", done); end
  endtask

  task automatic test_back_to_back();
    do_reset();
    start_packet(32'h8001_4002, 1'b0);
    push_frame(32'h8001_4002); push_idle(1);
    for (int c = 0; c < FR + 1; c++) begin
      @(negedge clock);
      exp_w = exp_q.pop_front();
      checks++; if (serial_out !== exp_w) begin errors++; $display("FAIL b2b_first c=%0d got %h exp %h", c, serial_out, exp_w); end
      if (c == 0) send_valid = 1'b0;
      if (c == FR) begin ack_valid = 1'b1; ack_pid = PID_ACK; ack_seq = 1'b0; end
    end
    @(negedge clock);
    ack_valid = 1'b0;
    checks++; if (done !== 1'b1 || send_ready !== 1'b1) begin errors++; $display("FAIL b2b_done got done=%b ready=%b exp 1 1", done, send_ready); end
    start_packet(32'h6C3A_95E7, 1'b1);
    push_frame(32'h6C3A_95E7);
    for (int c = 0; c < FR; c++) begin
      @(negedge clock);
      exp_w = exp_q.pop_front();
      checks++; if (serial_out !== exp_w) begin errors++; $display("FAIL b2b_second c=%0d got %h exp %h", c, serial_out, exp_w); end
      if (c == 0) send_valid = 1'b0;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got timeout exp completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset();
    test_ack();
    test_ge();
    test_timeout();
    test_bad_seq();
    test_ack_timeout();
    test_mid_reset();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
